seven_seg_reader: RTL and testbench
===================================

SEVEN_SEG_READER -- requirements
Module: SevenSeg_Reader

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, giving the number of consecutive identical samples (2..15) required before a digit is accepted.
REQ-002 SHALL use one clock and a synchronous, active-low reset.
REQ-003 Clk  input  1  rising-edge system clock.
REQ-004 nReset  input  1  synchronous active-low reset.
REQ-005 Segments  input  7  observed pattern, bit order gfedcba (bit 0 = a), active-high.
REQ-006 Anode  input  4  digit enables, active-low; exactly one low selects digit 0..3.
REQ-007 Ready  input  1  consumer accepts the event on an edge where Valid and Ready are both high.
REQ-008 Valid  output  1  an event is presented on Digit, Code and Error.
REQ-009 Digit  output  2  index of the digit that changed.
REQ-010 Code  output  6  decoded character code.
REQ-011 Error  output  1  Segments pattern was not a legal glyph.
REQ-012 Overflow  output  1  sticky flag: an event was dropped.
REQ-013 Codes  output  24  stored code bank; digit n is at bits [6n+5:6n].
REQ-014 CodesValid  output  4  per-digit flag: the stored code is valid.

Function
REQ-015 SHALL register Anode and Segments on every edge as the input stage.
REQ-016 A registered sample is a digit sample only when exactly one Anode bit is low; zero or several low bits form a blanking sample.
REQ-017 Stability counter (saturating at STABLE_CNT):
  - set to 1 on a digit sample whose (index, pattern) differs from the previous sample;
  - incremented on an identical digit sample;
  - cleared to 0 on a blanking sample.
REQ-018 Acceptance SHALL occur on the edge where the counter first reaches STABLE_CNT; the saturated counter SHALL NOT re-accept.
REQ-019 Decode (inverse of the team's 36-entry glyph table), by pattern:
  - 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9;
  - 1110111=10, 1111100=11, 0111001=12, 1011110=13, 1111001=14, 1110001=15, 0111101=16, 1110100=17, 0110000=18, 0011110=19, 1110101=20, 0111000=21, 0010101=22, 0110111=23, 1011100=24, 1110011=25, 1100111=26, 0110011=27, 1111000=29, 0111110=30, 0101110=31, 0101010=32, 1110110=33, 1101110=34, 1001011=35.
REQ-020 Pattern 1101101 SHALL decode to 5, never 28.
REQ-021 Pattern 0000000 SHALL decode to 63 with Error=0.
REQ-022 Any other pattern SHALL decode to 62 with Error=1.
REQ-023 On acceptance, if CodesValid[idx]=0 or the decoded code differs from the stored code, the block SHALL:
  - write the code to Codes[idx];
  - set CodesValid[idx];
  - generate an event.
REQ-024 An acceptance whose code equals the stored code SHALL generate no event.
REQ-025 Latency: with identical digit samples registered at edges E0..E0+STABLE_CNT-1, Valid, Codes and CodesValid SHALL update at edge E0+STABLE_CNT.
REQ-026 Output holding register, one deep:
  - Valid, Digit, Code and Error hold while Valid=1 and Ready=0;
  - Valid clears after a handshake edge unless a new event loads on that edge.
REQ-027 Event arrives on a handshake edge: the new event SHALL load and no loss is flagged.
REQ-028 Event arrives while Valid=1 and Ready=0: the new event SHALL be dropped from the handshake output, Overflow set, and Codes still updated.
REQ-029 Overflow SHALL clear only on reset.
REQ-030 Digit-index switches SHALL restart stability counting; per-digit stored codes SHALL persist across multiplex scanning.

Reset
REQ-031 When nReset=0 at an edge, the block SHALL clear:
  - Valid, Digit, Code, Error, Overflow, Codes, CodesValid;
  - the stability counter and the input-stage registers.
REQ-032 Reset mid-count or with an event pending SHALL discard the partial count and the pending event.
REQ-033 Acceptance SHALL restart only from fresh samples after reset is released.

Verification
REQ-034 Anode=1110, Segments=1001111 held 4 edges, Ready=1 -> Valid pulses one cycle with Digit=0, Code=3, Error=0; Codes[5:0]=3; CodesValid=0001.
REQ-035 Same input held a further 20 cycles -> no further Valid; Anode=1101 with Segments=1101101 for 4 edges -> Digit=1, Code=5.
REQ-036 Anode=1011, Segments=1000000 for 4 edges -> Code=62, Error=1, CodesValid[2]=1; Segments=0000000 for 4 edges -> Code=63, Error=0.
REQ-037 Ready=0 with Valid pending, then a second digit accepted -> first event held unchanged, Overflow=1, Codes updated for the second digit.
REQ-038 Pattern alternating every 2 cycles, or Anode=1111 inserted after 3 identical samples -> no acceptance; nReset=0 during a 3-sample count -> all outputs 0, and a subsequent acceptance requires 4 fresh samples.

Source files
------------

// File: rtl/seven_seg_reader.sv
// Seven-segment display snooper: samples a multiplexed display, debounces each
// digit, decodes its glyph into a character code and reports changes as handshake events.
module seven_seg_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [6:0]  Segments,
    input  logic [3:0]  Anode,
    input  logic        Ready,
    output logic        Valid,
    output logic [1:0]  Digit,
    output logic [5:0]  Code,
    output logic        Error,
    output logic        Overflow,
    output logic [23:0] Codes,
    output logic [3:0]  CodesValid
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    // Returns {error, code}; blank is a legal code, unknown patterns flag an error.
    function automatic logic [6:0] decode_glyph(input logic [6:0] pat);
        case (pat)
            7'b0111111: decode_glyph = {1'b0, 6'd0};
            7'b0000110: decode_glyph = {1'b0, 6'd1};
            7'b1011011: decode_glyph = {1'b0, 6'd2};
            7'b1001111: decode_glyph = {1'b0, 6'd3};
            7'b1100110: decode_glyph = {1'b0, 6'd4};
            7'b1101101: decode_glyph = {1'b0, 6'd5};
            7'b1111101: decode_glyph = {1'b0, 6'd6};
            7'b0000111: decode_glyph = {1'b0, 6'd7};
            7'b1111111: decode_glyph = {1'b0, 6'd8};
            7'b1101111: decode_glyph = {1'b0, 6'd9};
            7'b1110111: decode_glyph = {1'b0, 6'd10};
            7'b1111100: decode_glyph = {1'b0, 6'd11};
            7'b0111001: decode_glyph = {1'b0, 6'd12};
            7'b1011110: decode_glyph = {1'b0, 6'd13};
            7'b1111001: decode_glyph = {1'b0, 6'd14};
            7'b1110001: decode_glyph = {1'b0, 6'd15};
            7'b0111101: decode_glyph = {1'b0, 6'd16};
            7'b1110100: decode_glyph = {1'b0, 6'd17};
            7'b0110000: decode_glyph = {1'b0, 6'd18};
            7'b0011110: decode_glyph = {1'b0, 6'd19};
            7'b1110101: decode_glyph = {1'b0, 6'd20};
            7'b0111000: decode_glyph = {1'b0, 6'd21};
            7'b0010101: decode_glyph = {1'b0, 6'd22};
            7'b0110111: decode_glyph = {1'b0, 6'd23};
            7'b1011100: decode_glyph = {1'b0, 6'd24};
            7'b1110011: decode_glyph = {1'b0, 6'd25};
            7'b1100111: decode_glyph = {1'b0, 6'd26};
            7'b0110011: decode_glyph = {1'b0, 6'd27};
            7'b1111000: decode_glyph = {1'b0, 6'd29};
            7'b0111110: decode_glyph = {1'b0, 6'd30};
            7'b0101110: decode_glyph = {1'b0, 6'd31};
            7'b0101010: decode_glyph = {1'b0, 6'd32};
            7'b1110110: decode_glyph = {1'b0, 6'd33};
            7'b1101110: decode_glyph = {1'b0, 6'd34};
            7'b1001011: decode_glyph = {1'b0, 6'd35};
            7'b0000000: decode_glyph = {1'b0, 6'd63};
            default:    decode_glyph = {1'b1, 6'd62};
        endcase
    endfunction

    logic [3:0] anode_r;
    logic [6:0] seg_r;
    logic [1:0] prev_idx_r;
    logic [6:0] prev_seg_r;
    logic [3:0] cnt_r;
    logic [5:0] codes_r [4];
    logic [3:0] codes_valid_r;

    logic       is_digit_s;
    logic [1:0] idx_s;
    logic       same_s;
    logic [3:0] cnt_next_s;
    logic       accept_s;
    logic       event_s;
    logic       dec_err_s;
    logic [5:0] dec_code_s;

    // Sample classification, stability counting and change detection.
    always_comb begin
        is_digit_s = 1'b0;
        idx_s      = 2'd0;
        case (anode_r)
            4'b1110: begin is_digit_s = 1'b1; idx_s = 2'd0; end
            4'b1101: begin is_digit_s = 1'b1; idx_s = 2'd1; end
            4'b1011: begin is_digit_s = 1'b1; idx_s = 2'd2; end
            4'b0111: begin is_digit_s = 1'b1; idx_s = 2'd3; end
            default: begin is_digit_s = 1'b0; idx_s = 2'd0; end
        endcase
        // A zero count means the previous sample was blanking, so it never matches.
        same_s = (cnt_r != 4'd0) && (idx_s == prev_idx_r) && (seg_r == prev_seg_r);
        if (!is_digit_s) begin
            cnt_next_s = 4'd0;
        end else if (same_s) begin
            cnt_next_s = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + 4'd1;
        end else begin
            cnt_next_s = 4'd1;
        end
        accept_s = is_digit_s && same_s && (cnt_r == CNT_MAX - 4'd1);
        {dec_err_s, dec_code_s} = decode_glyph(seg_r);
        event_s = accept_s && (!codes_valid_r[idx_s] || (codes_r[idx_s] != dec_code_s));
    end

    // Input stage, counter, code bank and one-deep event holding register.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            anode_r       <= 4'd0;
            seg_r         <= 7'd0;
            prev_idx_r    <= 2'd0;
            prev_seg_r    <= 7'd0;
            cnt_r         <= 4'd0;
            codes_r       <= '{default: 6'd0};
            codes_valid_r <= 4'd0;
            Valid         <= 1'b0;
            Digit         <= 2'd0;
            Code          <= 6'd0;
            Error         <= 1'b0;
            Overflow      <= 1'b0;
        end else begin
            anode_r <= Anode;
            seg_r   <= Segments;
            cnt_r   <= cnt_next_s;
            if (is_digit_s) begin
                prev_idx_r <= idx_s;
                prev_seg_r <= seg_r;
            end
            if (event_s) begin
                codes_r[idx_s]       <= dec_code_s;
                codes_valid_r[idx_s] <= 1'b1;
            end
            if (event_s && (!Valid || Ready)) begin
                Valid <= 1'b1;
                Digit <= idx_s;
                Code  <= dec_code_s;
                Error <= dec_err_s;
            end else if (event_s) begin
                Overflow <= 1'b1;
            end else if (Valid && Ready) begin
                Valid <= 1'b0;
            end
        end
    end

    assign Codes      = {codes_r[3], codes_r[2], codes_r[1], codes_r[0]};
    assign CodesValid = codes_valid_r;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed self-checking bench for seven_seg_reader with STABLE_CNT=4.
module tb_seven_seg_reader;

    logic        Clk;
    logic        nReset;
    logic [6:0]  Segments;
    logic [3:0]  Anode;
    logic        Ready;
    logic        Valid;
    logic [1:0]  Digit;
    logic [5:0]  Code;
    logic        Error;
    logic        Overflow;
    logic [23:0] Codes;
    logic [3:0]  CodesValid;

    int tests_run;
    int tests_failed;
    logic seen;

    seven_seg_reader #(.STABLE_CNT(4)) dut (
        .Clk(Clk), .nReset(nReset), .Segments(Segments), .Anode(Anode),
        .Ready(Ready), .Valid(Valid), .Digit(Digit), .Code(Code),
        .Error(Error), .Overflow(Overflow), .Codes(Codes), .CodesValid(CodesValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Advance n cycles, remembering whether Valid was ever seen high.
    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1);
            seen = seen | Valid;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        nReset   = 1'b0;
        Anode    = 4'b1111;
        Segments = 7'd0;
        Ready    = 1'b1;
        tick(2);
        check("rst_valid", {31'd0, Valid}, 32'd0);
        check("rst_codes", {8'd0, Codes}, 32'd0);
        check("rst_cvalid", {28'd0, CodesValid}, 32'd0);
        check("rst_ovf", {31'd0, Overflow}, 32'd0);

        // Digit 0 shows '3'
        nReset   = 1'b1;
        Anode    = 4'b1110;
        Segments = 7'b1001111;
        tick(4);
        check("d0_early", {31'd0, Valid}, 32'd0);
        tick(1);
        check("d0_valid", {31'd0, Valid}, 32'd1);
        check("d0_digit", {30'd0, Digit}, 32'd0);
        check("d0_code", {26'd0, Code}, 32'd3);
        check("d0_err", {31'd0, Error}, 32'd0);
        check("d0_codes", {8'd0, Codes}, 32'h000003);
        check("d0_cvalid", {28'd0, CodesValid}, 32'b0001);
        tick(1);
        check("d0_pulse", {31'd0, Valid}, 32'd0);

        seen = 1'b0;
        watch(20);
        check("hold_noreaccept", {31'd0, seen}, 32'd0);

        // Digit 1 shows '5'
        Anode    = 4'b1101;
        Segments = 7'b1101101;
        tick(5);
        check("d1_valid", {31'd0, Valid}, 32'd1);
        check("d1_digit", {30'd0, Digit}, 32'd1);
        check("d1_code", {26'd0, Code}, 32'd5);
        check("d1_codes", {8'd0, Codes}, 32'h000143);
        tick(1);
        check("d1_pulse", {31'd0, Valid}, 32'd0);

        // Digit 2: illegal glyph, then blank
        Anode    = 4'b1011;
        Segments = 7'b1000000;
        tick(5);
        check("d2_bad_code", {26'd0, Code}, 32'd62);
        check("d2_bad_err", {31'd0, Error}, 32'd1);
        check("d2_cvalid", {28'd0, CodesValid}, 32'b0111);
        Segments = 7'b0000000;
        tick(5);
        check("d2_blank_valid", {31'd0, Valid}, 32'd1);
        check("d2_blank_code", {26'd0, Code}, 32'd63);
        check("d2_blank_err", {31'd0, Error}, 32'd0);
        check("d2_codes", {8'd0, Codes}, 32'h03F143);
        tick(1);

        // Consumer stalls; second event is dropped but still stored
        Ready    = 1'b0;
        Anode    = 4'b0111;
        Segments = 7'b0000110;
        tick(5);
        check("d3_valid", {31'd0, Valid}, 32'd1);
        check("d3_code", {26'd0, Code}, 32'd1);
        check("d3_ovf_before", {31'd0, Overflow}, 32'd0);
        Anode    = 4'b1110;
        Segments = 7'b0111111;
        tick(5);
        check("ovf_hold_valid", {31'd0, Valid}, 32'd1);
        check("ovf_hold_digit", {30'd0, Digit}, 32'd3);
        check("ovf_hold_code", {26'd0, Code}, 32'd1);
        check("ovf_flag", {31'd0, Overflow}, 32'd1);
        check("ovf_codes", {8'd0, Codes}, 32'h07F140);
        check("ovf_cvalid", {28'd0, CodesValid}, 32'b1111);
        Ready = 1'b1;
        tick(1);
        check("ovf_drain", {31'd0, Valid}, 32'd0);
        check("ovf_sticky", {31'd0, Overflow}, 32'd1);

        // Alternating pattern on digit 1 never stabilises
        seen  = 1'b0;
        Anode = 4'b1101;
        for (int k = 0; k < 6; k++) begin
            Segments = (k % 2 == 0) ? 7'b1111111 : 7'b0000110;
            watch(2);
        end
        check("alt_noaccept", {31'd0, seen}, 32'd0);

        // Blanking after three identical samples restarts the count
        seen     = 1'b0;
        Segments = 7'b1111111;
        for (int k = 0; k < 3; k++) begin
            Anode = 4'b1101;
            watch(3);
            Anode = 4'b1111;
            watch(1);
        end
        watch(2);
        check("blank_noaccept", {31'd0, seen}, 32'd0);

        // Reset in the middle of a count
        Anode    = 4'b1110;
        Segments = 7'b1111111;
        tick(3);
        nReset = 1'b0;
        tick(1);
        check("mid_rst_valid", {31'd0, Valid}, 32'd0);
        check("mid_rst_out", {23'd0, Digit, Code, Error}, 32'd0);
        check("mid_rst_codes", {8'd0, Codes}, 32'd0);
        check("mid_rst_cvalid", {28'd0, CodesValid}, 32'd0);
        check("mid_rst_ovf", {31'd0, Overflow}, 32'd0);
        nReset = 1'b1;
        tick(4);
        check("fresh_early", {31'd0, Valid}, 32'd0);
        tick(1);
        check("fresh_valid", {31'd0, Valid}, 32'd1);
        check("fresh_code", {26'd0, Code}, 32'd8);
        check("fresh_codes", {8'd0, Codes}, 32'h000008);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
